// File: rtl/uart_bar_pkg.sv
// Shared definitions for the UART/BAR bridges: register map, CTRL bit positions and
// receiver FSM state encoding.
package uart_bar_pkg;

   localparam logic [31:0] UART_DATA_OFS   = 32'h0000_0000;
   localparam logic [31:0] UART_STATUS_OFS = 32'h0000_0004;
   localparam logic [31:0] UART_CTRL_OFS   = 32'h0000_0008;

   localparam int unsigned CTRL_ENABLE_BIT = 0;
   localparam int unsigned CTRL_CLR_BIT    = 1;
   localparam int unsigned CTRL_IRQ_EN_BIT = 2;

   typedef logic [1:0] uart_rx_state_e;
   localparam uart_rx_state_e StIdle  = 2'd0;
   localparam uart_rx_state_e StStart = 2'd1;
   localparam uart_rx_state_e StData  = 2'd2;
   localparam uart_rx_state_e StStop  = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. A pop and a push in the same cycle are both
// honoured even when full; clr overrides everything.
module sync_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clr_i,
   input  logic                     push_i,
   input  logic [Width-1:0]         data_i,
   input  logic                     pop_i,
   output logic [Width-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(Depth):0]   count_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam logic [PtrW:0] DepthCnt = (PtrW+1)'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wptr_q, rptr_q;
   logic [PtrW:0]    count_q;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == DepthCnt);
   assign count_o = count_q;
   assign data_o  = mem_q[rptr_q];

   assign do_pop  = pop_i & ~empty_o;
   // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else if (clr_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + PtrW'(1);
         if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (PtrW+1)'(1);
            2'b01:   count_q <= count_q - (PtrW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/uart_bar_rx_bridge.sv
// 8N1 UART receiver feeding a byte FIFO, exposed to the host through a 3-word
// PCIe BAR register window (DATA / STATUS / CTRL).
module uart_bar_rx_bridge
   import uart_bar_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_1010
) (
   input  logic        clk_main_a0,
   input  logic        rst_main_n,
   input  logic        uart_line,
   input  logic [31:0] pcie_bar_addr,
   input  logic [31:0] pcie_bar_wdata,
   input  logic        pcie_bar_wen,
   input  logic        pcie_bar_ren,
   output logic [31:0] pcie_bar_rdata,
   output logic        bar_hit,
   output logic        rx_irq
);

   localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
   localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
   localparam logic [TimerW-1:0] HalfLoad = TimerW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TimerW-1:0] FullLoad = TimerW'(CLKS_PER_BIT - 1);

   // Line synchronizer and edge detect
   logic [1:0] sync_q;
   logic       line_prev_q;
   logic       line_s, line_fall;

   assign line_s    = sync_q[1];
   assign line_fall = line_prev_q & ~line_s;

   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         sync_q      <= 2'b11;
         line_prev_q <= 1'b1;
      end else begin
         sync_q      <= {sync_q[0], uart_line};
         line_prev_q <= line_s;
      end
   end

   // Receiver FSM
   uart_rx_state_e    state_q, state_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic              timer_done, rx_push, rx_frame_err;
   logic              enable_q, irq_en_q, overrun_q, frame_err_q;

   assign timer_done = (timer_q == '0);

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      rx_push      = 1'b0;
      rx_frame_err = 1'b0;
      case (state_q)
         StIdle: begin
            if (line_fall) begin
               state_d = StStart;
               timer_d = HalfLoad;
            end
         end
         StStart: begin
            if (!timer_done) begin
               timer_d = timer_q - TimerW'(1);
            end else if (!line_s) begin
               state_d   = StData;
               timer_d   = FullLoad;
               bit_idx_d = '0;
            end else begin
               state_d = StIdle;
            end
         end
         StData: begin
            if (!timer_done) begin
               timer_d = timer_q - TimerW'(1);
            end else begin
               shift_d   = {line_s, shift_q[7:1]};
               timer_d   = FullLoad;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = StStop;
            end
         end
         StStop: begin
            if (!timer_done) begin
               timer_d = timer_q - TimerW'(1);
            end else begin
               state_d      = StIdle;
               rx_push      = line_s;
               rx_frame_err = ~line_s;
            end
         end
         default: state_d = StIdle;
      endcase
      if (!enable_q) begin
         state_d      = StIdle;
         rx_push      = 1'b0;
         rx_frame_err = 1'b0;
      end
   end

   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         state_q   <= StIdle;
         timer_q   <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
      end
   end

   // Register window
   logic          hit_data, hit_status, hit_ctrl, in_win;
   logic          ctrl_wr, fifo_clr, fifo_pop, overrun_set;
   logic          fifo_full, fifo_empty;
   logic [7:0]    fifo_rdata;
   logic [PtrW:0] fifo_count;
   logic [4:0]    count5;
   logic [31:0]   rd_val, rdata_q;
   logic          bar_hit_q;
   logic          unused_wdata;

   assign hit_data    = (pcie_bar_addr == BASE_ADDR + UART_DATA_OFS);
   assign hit_status  = (pcie_bar_addr == BASE_ADDR + UART_STATUS_OFS);
   assign hit_ctrl    = (pcie_bar_addr == BASE_ADDR + UART_CTRL_OFS);
   assign in_win      = hit_data | hit_status | hit_ctrl;
   assign ctrl_wr     = pcie_bar_wen & hit_ctrl;
   assign fifo_clr    = ctrl_wr & pcie_bar_wdata[CTRL_CLR_BIT];
   assign fifo_pop    = pcie_bar_ren & hit_data & ~fifo_empty;
   assign overrun_set = rx_push & fifo_full & ~fifo_pop;
   assign count5      = 5'(fifo_count);
   assign unused_wdata = ^pcie_bar_wdata[31:3];

   sync_fifo #(
      .Width (8),
      .Depth (FIFO_DEPTH)
   ) u_rx_fifo (
      .clk_i   (clk_main_a0),
      .rst_ni  (rst_main_n),
      .clr_i   (fifo_clr),
      .push_i  (rx_push),
      .data_i  (shift_q),
      .pop_i   (fifo_pop),
      .data_o  (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      rd_val = '0;
      if (hit_data) begin
         rd_val = {23'b0, ~fifo_empty, fifo_empty ? 8'h00 : fifo_rdata};
      end else if (hit_status) begin
         rd_val = {24'b0, overrun_q, frame_err_q, count5, fifo_empty};
      end else if (hit_ctrl) begin
         rd_val = {29'b0, irq_en_q, 1'b0, enable_q};
      end
   end

   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         rdata_q     <= '0;
         bar_hit_q   <= 1'b0;
         enable_q    <= 1'b1;
         irq_en_q    <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         bar_hit_q <= pcie_bar_ren & in_win;
         if (pcie_bar_ren && in_win) rdata_q <= rd_val;
         if (ctrl_wr) begin
            enable_q <= pcie_bar_wdata[CTRL_ENABLE_BIT];
            irq_en_q <= pcie_bar_wdata[CTRL_IRQ_EN_BIT];
         end
         if (fifo_clr) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
         end else begin
            if (overrun_set)  overrun_q   <= 1'b1;
            if (rx_frame_err) frame_err_q <= 1'b1;
         end
      end
   end

   assign pcie_bar_rdata = rdata_q;
   assign bar_hit        = bar_hit_q;
   assign rx_irq         = ~fifo_empty & irq_en_q;

endmodule

// File: doc/uart_bar_rx_bridge.md
# uart_bar_rx_bridge

Host-side UART receiver that deserializes the SoC's `io_uart_tx` serial line (8N1) into bytes. Bytes are buffered in a FIFO and exposed to the host through the same PCIe BAR register window that drives `uart_rx` and GPIO. It sits in the FPGA top level beside the SoC instance and replaces single-bit polling of `uart_tx` with byte-level console capture.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 8.
- `FIFO_DEPTH`, default 16: number of receive FIFO entries. Must be a power of two.
- `BASE_ADDR`, default 32'h0000_1010: base of this block's 3-word register window.

Ports:
- `clk_main_a0`, input, 1: sole clock.
- `rst_main_n`, input, 1: reset, asynchronous assert, active-low.
- `uart_line`, input, 1: serial line from SoC `io_uart_tx`; idles high; asynchronous to the block.
- `pcie_bar_addr`, input, 32: BAR byte address.
- `pcie_bar_wdata`, input, 32: BAR write data.
- `pcie_bar_wen`, input, 1: single-cycle write strobe.
- `pcie_bar_ren`, input, 1: single-cycle read strobe.
- `pcie_bar_rdata`, output, 32: registered read data.
- `bar_hit`, output, 1: registered; high one cycle after a read addressed this window. The top level uses it as the read-mux select.
- `rx_irq`, output, 1: high while the FIFO is non-empty and `CTRL.irq_en` = 1.

## Operation

Registers (word offsets from `BASE_ADDR`):
- +0x0 `DATA` (read-only): returns `{23'b0, valid, byte[7:0]}` and pops one entry. If the FIFO is empty, returns 0 with `valid` = 0 and does not pop.
- +0x4 `STATUS` (read-only): `{24'b0, overrun, frame_err, count[4:0], empty}`. `overrun` and `frame_err` are sticky. `count` is 0..`FIFO_DEPTH`. Reading `STATUS` has no side effects.
- +0x8 `CTRL` (read/write): `{29'b0, irq_en, clr, enable}`. `clr` is write-1 self-clearing; it empties the FIFO and clears both sticky flags, and always reads back 0. Reset values: `enable` = 1, `irq_en` = 0.
- Writes to +0x0 or +0x4 are ignored. Any address outside the window produces no response and leaves `bar_hit` = 0.

Receiver:
- `uart_line` passes through a 2-flop synchronizer before any use. The synchronizer resets to 1.
- FSM states: `IDLE`, `START`, `DATA`, `STOP`.
  - `IDLE`: a falling edge on the synchronized line moves to `START` and loads the bit timer with `CLKS_PER_BIT/2 - 1`.
  - `START`: at the timer expiry (the bit midpoint), a low line moves to `DATA` with the timer reloaded to `CLKS_PER_BIT - 1`. A high line counts as a glitch and returns to `IDLE`.
  - `DATA`: samples 8 bits LSB-first, one per `CLKS_PER_BIT` cycles, then moves to `STOP`.
  - `STOP`: samples one bit period later. A high stop bit pushes the byte; a low stop bit sets `frame_err`, discards the byte, and returns to `IDLE`.
- `enable` = 0 forces the FSM to `IDLE`, which aborts any frame in progress. The FIFO stays readable.
- A push while the FIFO is full drops the new byte and sets `overrun`; existing contents are unchanged.

## Timing

- Reset values: `pcie_bar_rdata` = 0, `bar_hit` = 0, `rx_irq` = 0. FIFO is empty, sticky flags are clear, FSM is in `IDLE`.
- The 2-flop synchronizer adds 2 cycles of line latency.
- A received byte is visible in `count`, `empty`, and `rx_irq` on the cycle after the stop-bit sample cycle.
- Read latency is 1 cycle: `pcie_bar_rdata` and `bar_hit` update on the edge following `pcie_bar_ren`. `pcie_bar_rdata` holds its value until the next in-window read.
- Simultaneous push and pop in the same cycle are both performed and `count` is unchanged. This holds when the FIFO is full, in which case no overrun is flagged.
- Simultaneous `clr` and push: `clr` wins, and the FIFO is empty on the next cycle.
- Pointers are log2(`FIFO_DEPTH`) bits wide and wrap naturally. `count` is one bit wider than the pointers.
- Reset asserted mid-frame returns everything to reset values immediately, regardless of clock.

## Structure

- Shared package `uart_bar_pkg`:
  - register offset constants `UART_DATA_OFS`, `UART_STATUS_OFS`, `UART_CTRL_OFS`;
  - the FSM state enum;
  - the `CTRL` bit index constants.
- One sub-module, `sync_fifo`: parameterized width and depth, with push/pop/clr inputs and full/empty/count outputs. It is reused by the planned TX bridge.

## Test plan

1. `CLKS_PER_BIT` = 16. Drive byte 0xA5 on `uart_line`, then read `DATA` → 0x0000_01A5. A following `STATUS` read → `empty` = 1, `count` = 0.
2. Drive a 5-cycle low glitch on the idle line → no push; `STATUS` = 0x0000_0001.
3. Drive frame 0x3C with the stop bit held low → `frame_err` = 1, `count` = 0. Write `CTRL` = 0x3 → `STATUS` = 0x0000_0001.
4. Send 17 bytes 0x00..0x10 with no reads → `count` = 16, `overrun` = 1. Sixteen `DATA` reads return 0x100..0x10F in order; the 17th read returns 0x0000_0000.
5. Fill the FIFO to 16 entries. Issue a `DATA` read in the same cycle as the 17th byte's push → `count` stays 16, `overrun` = 0.
6. Assert `rst_main_n` low during data bit 4 of a frame → `rdata` = 0, `bar_hit` = 0, FIFO empty. After release, the next full byte 0x5A is received correctly.
